// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared op-code and state types for the multiply/divide unit
package mips_cpu_pkg;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} muldiv_state_t;
endpackage

// File: rtl/mips_cpu_muldiv_unit_if.sv
// mips_cpu_muldiv_unit_if: request/result bundle between decoder and the HI/LO unit
interface mips_cpu_muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, op, operand_a, operand_b, input busy, done, hi, lo);
    modport slave (input start, op, operand_a, operand_b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv_unit.sv
// mips_cpu_muldiv_unit: 32-step shift-add multiplier / restoring divider owning HI and LO
module mips_cpu_muldiv_unit
    import mips_cpu_pkg::*;
(
    input logic clk,
    input logic reset,
    mips_cpu_muldiv_unit_if.slave bus
);
    muldiv_state_t state, state_nxt;
    logic [4:0]  cnt;
    logic [63:0] work;
    logic [31:0] mcand;
    logic        is_div, neg_q, neg_r, done_r;
    logic [31:0] hi_r, lo_r;
    logic        accept, arith, div_op, sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum, div_diff;
    logic [63:0] work_step, prod;
    logic [31:0] quo, rem;

    assign accept = state == IDLE && bus.start;
    assign arith  = accept && !bus.op[2];
    assign div_op = bus.op[1];
    // Signed variants (MULT, DIV) have op[0] clear
    assign sign_a = !bus.op[0] && bus.operand_a[31];
    assign sign_b = !bus.op[0] && bus.operand_b[31];
    assign mag_a  = sign_a ? -bus.operand_a : bus.operand_a;
    assign mag_b  = sign_b ? -bus.operand_b : bus.operand_b;

    // One iteration of the shared datapath plus the final sign correction
    always_comb begin
        mul_sum   = {1'b0, work[63:32]} + {1'b0, work[0] ? mcand : 32'd0};
        div_diff  = work[63:31] - {1'b0, mcand};
        work_step = !is_div ? {mul_sum, work[31:1]} :
                    div_diff[32] ? {work[62:0], 1'b0} : {div_diff[31:0], work[30:0], 1'b1};
        prod      = neg_q ? -work : work;
        quo       = neg_q ? -work[31:0] : work[31:0];
        rem       = neg_r ? -work[63:32] : work[63:32];
    end

    // Next-state: 32 RUN cycles then one FINISH cycle that commits HI/LO
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE && arith) ? RUN :
                    (state == RUN && cnt == 5'd31) ? FINISH :
                    (state == FINISH) ? IDLE : state;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand capture, iteration and HI/LO writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= 5'd0;
            work   <= 64'd0;
            mcand  <= 32'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
        end else begin
            done_r <= state == FINISH;
            if (arith) begin
                work   <= {32'd0, div_op ? mag_a : mag_b};
                mcand  <= div_op ? mag_b : mag_a;
                cnt    <= 5'd0;
                is_div <= div_op;
                neg_q  <= sign_a ^ sign_b;
                neg_r  <= sign_a;
            end else if (state == RUN) begin
                work <= work_step;
                cnt  <= cnt + 5'd1;
            end
            if (state == FINISH) begin
                hi_r <= is_div ? rem : prod[63:32];
                lo_r <= is_div ? quo : prod[31:0];
            end else if (accept && bus.op == OP_MTHI) begin
                hi_r <= bus.operand_a;
            end else if (accept && bus.op == OP_MTLO) begin
                lo_r <= bus.operand_a;
            end
        end
    end

    assign bus.busy = state != IDLE;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// tb_mips_cpu_muldiv_unit: directed vectors for the HI/LO multiply/divide unit
module tb_mips_cpu_muldiv_unit;
    import mips_cpu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    mips_cpu_muldiv_unit_if bus();

    mips_cpu_muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request for the current cycle; returns in the following cycle
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
    endtask

    // Called in cycle N+1; returns in cycle N+34 after checking the result
    task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el, input bit inj);
        logic [31:0] lo0;
        lo0 = bus.lo;
        check({tag, " busy@1"}, 64'(bus.busy), 64'd1);
        check({tag, " done@1"}, 64'(bus.done), 64'd0);
        for (int i = 2; i <= 33; i++) begin
            @(negedge clk);
            if (inj) begin
                bus.op = OP_MTLO;
                bus.operand_a = 32'hDEADBEEF;
            end
            bus.start = inj && i == 5;
        end
        check({tag, " busy@33"}, 64'(bus.busy), 64'd1);
        check({tag, " done@33"}, 64'(bus.done), 64'd0);
        if (inj) check({tag, " lo kept in flight"}, 64'(bus.lo), 64'(lo0));
        @(negedge clk);
        check({tag, " done@34"}, 64'(bus.done), 64'd1);
        check({tag, " busy@34"}, 64'(bus.busy), 64'd0);
        check({tag, " hi"}, 64'(bus.hi), 64'(eh));
        check({tag, " lo"}, 64'(bus.lo), 64'(el));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.operand_a = 32'd0;
        bus.operand_b = 32'd0;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst hi", 64'(bus.hi), 64'd0);
        check("rst lo", 64'(bus.lo), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(OP_MULT, 32'hFFFFFFFE, 32'h3);
        wait_done("mult -2*3", 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        @(negedge clk);
        check("done pulse width", 64'(bus.done), 64'd0);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu max", 32'hFFFFFFFE, 32'h00000001, 1'b0);
        issue(OP_DIV, 32'hFFFFFFF9, 32'h2);
        wait_done("b2b div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div min/-1", 32'h0, 32'h80000000, 1'b0);
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_done("divu 7/0", 32'd7, 32'hFFFFFFFF, 1'b0);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd0);
        wait_done("div -7/0", 32'hFFFFFFF9, 32'd1, 1'b0);

        issue(OP_MTHI, 32'h12345678, 32'h0);
        check("mthi hi", 64'(bus.hi), 64'h12345678);
        check("mthi lo kept", 64'(bus.lo), 64'd1);
        check("mthi busy", 64'(bus.busy), 64'd0);
        check("mthi done", 64'(bus.done), 64'd0);
        issue(OP_MTLO, 32'hCAFEF00D, 32'h0);
        check("mtlo lo", 64'(bus.lo), 64'hCAFEF00D);
        check("mtlo hi kept", 64'(bus.hi), 64'h12345678);

        issue(3'd6, 32'h11111111, 32'h22222222);
        check("nop busy", 64'(bus.busy), 64'd0);
        check("nop hi", 64'(bus.hi), 64'h12345678);
        check("nop lo", 64'(bus.lo), 64'hCAFEF00D);

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done("divu 100/7", 32'd2, 32'd14, 1'b0);
        issue(OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFC);
        wait_done("mult -3*-4", 32'd0, 32'd12, 1'b0);
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
        wait_done("div 7/-2", 32'd1, 32'hFFFFFFFD, 1'b0);
        issue(OP_MULTU, 32'h00010000, 32'h00010000);
        wait_done("multu mtlo busy", 32'd1, 32'd0, 1'b1);

        issue(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF);
        repeat (9) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("midrun rst busy", 64'(bus.busy), 64'd0);
        check("midrun rst hi", 64'(bus.hi), 64'd0);
        check("midrun rst lo", 64'(bus.lo), 64'd0);
        check("midrun rst done", 64'(bus.done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(OP_MULT, 32'd5, 32'd6);
        wait_done("mult 5*6", 32'd0, 32'd30, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
